// File: rtl/conv_layer_sequencer_pkg.sv
// Shared constants for the convolution layer sequencer: FSM encodings and
// the packed descriptor width {last, result, kernel, pixel}.
package conv_layer_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  function automatic int descWidth(input int addrW);
    return 3 * addrW + 1;
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Job descriptor channel plus the Convolution2D control/address channel.
// The sequencer uses the slave view; the host/engine side uses master.
interface conv_layer_sequencer_if #(
  parameter int ADDR_W = 14
) ();

  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_pix_addr;
  logic [ADDR_W-1:0] job_kernel_addr;
  logic [ADDR_W-1:0] job_result_addr;
  logic              job_last;

  logic [ADDR_W-1:0] pix_base_addr;
  logic [ADDR_W-1:0] kernel_base_addr;
  logic [ADDR_W-1:0] base_result_addr;
  logic              en_conv2d;
  logic              conv_completed;

  modport master (
    output job_valid, job_pix_addr, job_kernel_addr, job_result_addr, job_last,
    output conv_completed,
    input  job_ready, pix_base_addr, kernel_base_addr, base_result_addr, en_conv2d
  );

  modport slave (
    input  job_valid, job_pix_addr, job_kernel_addr, job_result_addr, job_last,
    input  conv_completed,
    output job_ready, pix_base_addr, kernel_base_addr, base_result_addr, en_conv2d
  );

endinterface

// File: rtl/conv_layer_sequencer_job_fifo.sv
// Synchronous descriptor FIFO with flags derived from a registered occupancy
// count; DEPTH must be a power of two so the pointers wrap naturally.
module conv_job_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [PW:0]      count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs queued Convolution2D layer jobs back-to-back: LOAD latches a descriptor,
// RUN waits for completion under a watchdog, GAP holds en_conv2d low before the next job.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_layer_sequencer_if.slave  bus,
  input  logic                   err_clr_i,
  output logic                   busy_o,
  output logic                   layer_done_o,
  output logic                   net_done_o,
  output logic                   timeout_err_o,
  output logic [7:0]             jobs_done_o
);

  localparam int DW    = descWidth(ADDR_W);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [DW-1:0]        pushData, headData;
  logic                 fifoFull, fifoEmpty, fifoPush, fifoPop;

  logic [1:0]           state_q, state_d;
  logic [GAP_W-1:0]     gapCnt_q, gapCnt_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d, wdogInc;
  logic [ADDR_W-1:0]    pix_q, pix_d, ker_q, ker_d, res_q, res_d;
  logic                 last_q, last_d, en_q, en_d;
  logic                 layerDone_q, layerDone_d, netDone_q, netDone_d;
  logic                 timeoutErr_q, timeoutErr_d;
  logic [7:0]           jobsDone_q, jobsDone_d;

  assign pushData = {bus.job_last, bus.job_result_addr, bus.job_kernel_addr, bus.job_pix_addr};
  assign fifoPush = bus.job_valid && !fifoFull;
  assign fifoPop  = (state_q == ST_LOAD);
  assign bus.job_ready = !fifoFull;

  conv_job_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i (pushData),
    .rdata_o (headData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign wdogInc = wdog_q + 1'b1;

  // Completion is checked before the watchdog, so a job finishing on the
  // abort cycle still counts; a timeout set beats a simultaneous err_clr.
  always_comb begin
    state_d      = state_q;
    gapCnt_d     = gapCnt_q;
    wdog_d       = wdog_q;
    pix_d        = pix_q;
    ker_d        = ker_q;
    res_d        = res_q;
    last_d       = last_q;
    en_d         = en_q;
    layerDone_d  = 1'b0;
    netDone_d    = 1'b0;
    jobsDone_d   = jobsDone_q;
    timeoutErr_d = err_clr_i ? 1'b0 : timeoutErr_q;
    case (state_q)
      ST_IDLE: if (!fifoEmpty) state_d = ST_LOAD;
      ST_LOAD: begin
        {last_d, res_d, ker_d, pix_d} = headData;
        wdog_d  = '0;
        en_d    = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        wdog_d = wdogInc;
        if (bus.conv_completed) begin
          layerDone_d = 1'b1;
          netDone_d   = last_q;
          jobsDone_d  = jobsDone_q + 8'd1;
          en_d        = 1'b0;
          gapCnt_d    = '0;
          state_d     = ST_GAP;
        end else if (&wdogInc) begin
          timeoutErr_d = 1'b1;
          en_d         = 1'b0;
          gapCnt_d     = '0;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == GAP_LAST) state_d = ST_IDLE;
        else gapCnt_d = gapCnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gapCnt_q     <= '0;
      wdog_q       <= '0;
      pix_q        <= '0;
      ker_q        <= '0;
      res_q        <= '0;
      last_q       <= 1'b0;
      en_q         <= 1'b0;
      layerDone_q  <= 1'b0;
      netDone_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
      jobsDone_q   <= '0;
    end else begin
      state_q      <= state_d;
      gapCnt_q     <= gapCnt_d;
      wdog_q       <= wdog_d;
      pix_q        <= pix_d;
      ker_q        <= ker_d;
      res_q        <= res_d;
      last_q       <= last_d;
      en_q         <= en_d;
      layerDone_q  <= layerDone_d;
      netDone_q    <= netDone_d;
      timeoutErr_q <= timeoutErr_d;
      jobsDone_q   <= jobsDone_d;
    end
  end

  assign bus.pix_base_addr    = pix_q;
  assign bus.kernel_base_addr = ker_q;
  assign bus.base_result_addr = res_q;
  assign bus.en_conv2d        = en_q;
  assign busy_o        = (state_q != ST_IDLE) || !fifoEmpty;
  assign layer_done_o  = layerDone_q;
  assign net_done_o    = netDone_q;
  assign timeout_err_o = timeoutErr_q;
  assign jobs_done_o   = jobsDone_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench: a Convolution2D stand-in answers en_conv2d, and a job-level
// scoreboard checks start order, addresses, pulses, gaps and watchdog length.
module tb_conv_layer_sequencer;

  localparam int AW    = 14;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int TW    = 7;
  localparam int TMAX  = (1 << TW) - 1;

  typedef struct {
    logic [AW-1:0] pix;
    logic [AW-1:0] ker;
    logic [AW-1:0] res;
    logic          last;
  } job_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       errClr = 1'b0;
  logic       busy, layerDone, netDone, timeoutErr;
  logic [7:0] jobsDone;

  conv_layer_sequencer_if #(.ADDR_W(AW)) bus ();

  conv_layer_sequencer #(
    .ADDR_W(AW), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_W(TW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .err_clr_i     (errClr),
    .busy_o        (busy),
    .layer_done_o  (layerDone),
    .net_done_o    (netDone),
    .timeout_err_o (timeoutErr),
    .jobs_done_o   (jobsDone)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0;
  job_t expQ[$];
  job_t curJob;
  int ldCount = 0, ndCount = 0, toCount = 0, riseCount = 0, strayCount = 0;
  int lastAcceptCyc = 0, lastRiseCyc = 0, highCnt = 0, lowCnt = 0;
  bit prevEn = 1'b0, seenFall = 1'b0;
  int respMode = 0, latMin = 1, latMax = 1;
  int expDone = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one descriptor; it is accepted on the first edge where job_ready is seen high.
  task automatic applyStimulus(input job_t j, input int budget);
    int  waited = 0;
    bit  ok = 1'b0;
    bus.job_valid       = 1'b1;
    bus.job_pix_addr    = j.pix;
    bus.job_kernel_addr = j.ker;
    bus.job_result_addr = j.res;
    bus.job_last        = j.last;
    while (!ok && waited < budget) begin
      if (bus.job_ready) begin
        ok = 1'b1;
        expQ.push_back(j);
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (ok) lastAcceptCyc = cyc;
    bus.job_valid = 1'b0;
    checkOutput("pushAccepted", 32'(ok), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int w = 0;
    while (busy && w < budget) begin
      waitCycles(1);
      w++;
    end
    checkOutput("idleReached", 32'(busy), 32'd0);
  endtask

  function automatic job_t randJob();
    job_t j;
    j.pix  = AW'($urandom);
    j.ker  = AW'($urandom);
    j.res  = AW'($urandom);
    j.last = ($urandom_range(0, 7) == 0);
    return j;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Convolution2D stand-in: mode 0 never completes, 1 pulses after a
  // per-job latency, 2 raises conv_completed and then leaves it high.
  initial begin
    int enCnt = 0;
    int latCur = 1;
    bus.conv_completed = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.en_conv2d) begin
        enCnt++;
        if (enCnt == 1) latCur = int'($urandom_range(latMax, latMin));
      end else begin
        enCnt = 0;
      end
      case (respMode)
        1: bus.conv_completed = bus.en_conv2d && (enCnt >= latCur);
        2: if (bus.en_conv2d && enCnt >= latCur) bus.conv_completed = 1'b1;
        default: bus.conv_completed = 1'b0;
      endcase
    end
  end

  // Job-level monitor: each en rise must start the oldest accepted descriptor;
  // each fall is either a normal completion or a full-length watchdog abort.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prevEn   = 1'b0;
      seenFall = 1'b0;
      highCnt  = 0;
      lowCnt   = 0;
    end else begin
      if (bus.en_conv2d && !prevEn) begin
        riseCount++;
        lastRiseCyc = cyc;
        if (seenFall) checkOutput("gapAtLeastMin", 32'(lowCnt >= GAP), 32'd1);
        checkOutput("startHasJob", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          curJob = expQ.pop_front();
          checkOutput("startPix", 32'(bus.pix_base_addr), 32'(curJob.pix));
          checkOutput("startKer", 32'(bus.kernel_base_addr), 32'(curJob.ker));
          checkOutput("startRes", 32'(bus.base_result_addr), 32'(curJob.res));
        end
        highCnt = 1;
      end else if (bus.en_conv2d) begin
        highCnt++;
      end
      if (!bus.en_conv2d && prevEn) begin
        seenFall = 1'b1;
        lowCnt   = 1;
        if (layerDone) begin
          ldCount++;
          if (netDone) ndCount++;
          checkOutput("netDoneFlag", 32'(netDone), 32'(curJob.last));
          checkOutput("holdPix", 32'(bus.pix_base_addr), 32'(curJob.pix));
          checkOutput("holdRes", 32'(bus.base_result_addr), 32'(curJob.res));
        end else begin
          toCount++;
          checkOutput("wdogRunLen", 32'(highCnt), 32'(TMAX));
          checkOutput("toErrSet", 32'(timeoutErr), 32'd1);
        end
      end else if (!bus.en_conv2d) begin
        lowCnt++;
      end
      if (layerDone && !(prevEn && !bus.en_conv2d)) strayCount++;
      if (netDone && !layerDone) strayCount++;
      prevEn = bus.en_conv2d;
    end
  end

  initial begin
    job_t j;
    int a1, w, ldBase, ndBase, riseBase, toBase;
    bus.job_valid       = 1'b0;
    bus.job_pix_addr    = '0;
    bus.job_kernel_addr = '0;
    bus.job_result_addr = '0;
    bus.job_last        = 1'b0;

    $display("[TB] reset state");
    waitCycles(3);
    checkOutput("rstEn", 32'(bus.en_conv2d), 32'd0);
    checkOutput("rstPix", 32'(bus.pix_base_addr), 32'd0);
    checkOutput("rstKer", 32'(bus.kernel_base_addr), 32'd0);
    checkOutput("rstRes", 32'(bus.base_result_addr), 32'd0);
    checkOutput("rstReady", 32'(bus.job_ready), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstJobsDone", 32'(jobsDone), 32'd0);
    checkOutput("rstTimeoutErr", 32'(timeoutErr), 32'd0);
    checkOutput("rstLayerDone", 32'(layerDone), 32'd0);
    checkOutput("rstNetDone", 32'(netDone), 32'd0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] ping-pong chain");
    respMode = 1; latMin = 100; latMax = 100;
    ldBase = ldCount; ndBase = ndCount;
    j.pix = 14'd0; j.ker = 14'd6912; j.res = 14'd10000; j.last = 1'b0;
    applyStimulus(j, 20);
    a1 = lastAcceptCyc;
    j.pix = 14'd10000; j.ker = 14'd6912; j.res = 14'd0; j.last = 1'b1;
    applyStimulus(j, 20);
    waitCycles(2);
    checkOutput("firstEnLatency", 32'(lastRiseCyc - a1), 32'd2);
    waitIdle(600);
    checkOutput("ppLayerDone", 32'(ldCount - ldBase), 32'd2);
    checkOutput("ppNetDone", 32'(ndCount - ndBase), 32'd1);
    checkOutput("ppJobsDone", 32'(jobsDone), 32'd2);
    checkOutput("ppPixHeld", 32'(bus.pix_base_addr), 32'd10000);
    expDone = 2;

    $display("[TB] random jobs through jobs_done wrap");
    latMin = 1; latMax = 6;
    ldBase = ldCount;
    for (int n = 0; n < 258; n++) begin
      applyStimulus(randJob(), 200);
      waitCycles($urandom_range(0, 3));
    end
    waitIdle(3000);
    expDone += 258;
    checkOutput("rndLayerDone", 32'(ldCount - ldBase), 32'd258);
    checkOutput("rndQueueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("wrapJobsDone", 32'(jobsDone), 32'(expDone % 256));

    $display("[TB] back-pressure");
    respMode = 0;
    toBase = toCount; riseBase = riseCount;
    for (int i = 0; i < 5; i++) begin
      j = randJob();
      applyStimulus(j, 20);
    end
    checkOutput("bpReadyLow", 32'(bus.job_ready), 32'd0);
    checkOutput("bpBusy", 32'(busy), 32'd1);
    checkOutput("bpOneRunning", 32'(riseCount - riseBase), 32'd1);
    applyStimulus(randJob(), 400);
    checkOutput("bpSixthAfterPop", 32'(toCount - toBase), 32'd1);
    respMode = 1; latMin = 2; latMax = 5;
    waitIdle(600);
    expDone += 5;
    checkOutput("bpAllStarted", 32'(riseCount - riseBase), 32'd6);
    checkOutput("bpQueueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("bpTimeouts", 32'(toCount - toBase), 32'd1);
    checkOutput("bpJobsDone", 32'(jobsDone), 32'(expDone % 256));

    $display("[TB] watchdog and error clear");
    checkOutput("toSticky", 32'(timeoutErr), 32'd1);
    errClr = 1'b1;
    waitCycles(1);
    errClr = 1'b0;
    checkOutput("toCleared", 32'(timeoutErr), 32'd0);
    respMode = 0;
    errClr = 1'b1;
    toBase = toCount; ldBase = ldCount;
    applyStimulus(randJob(), 20);
    applyStimulus(randJob(), 20);
    w = 0;
    while (toCount == toBase && w < 300) begin
      waitCycles(1);
      w++;
    end
    checkOutput("wdFired", 32'(toCount - toBase), 32'd1);
    checkOutput("wdNoLayerDone", 32'(ldCount - ldBase), 32'd0);
    checkOutput("wdClrHeld", 32'(timeoutErr), 32'd0);
    errClr = 1'b0;
    respMode = 1; latMin = 3; latMax = 3;
    waitIdle(100);
    expDone += 1;
    checkOutput("wdNextJobDone", 32'(ldCount - ldBase), 32'd1);
    checkOutput("wdJobsDone", 32'(jobsDone), 32'(expDone % 256));

    $display("[TB] stale completion");
    respMode = 2; latMin = 1; latMax = 1;
    ldBase = ldCount;
    applyStimulus(randJob(), 20);
    waitIdle(100);
    waitCycles(8);
    expDone += 1;
    checkOutput("staleOneDone", 32'(ldCount - ldBase), 32'd1);
    checkOutput("staleJobsDone", 32'(jobsDone), 32'(expDone % 256));
    checkOutput("staleIdle", 32'(busy), 32'd0);
    respMode = 0;
    waitCycles(2);

    $display("[TB] reset during RUN");
    riseBase = riseCount;
    for (int i = 0; i < 3; i++) applyStimulus(randJob(), 20);
    w = 0;
    while (riseCount == riseBase && w < 20) begin
      waitCycles(1);
      w++;
    end
    checkOutput("mrStarted", 32'(riseCount - riseBase), 32'd1);
    waitCycles(10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrEnLow", 32'(bus.en_conv2d), 32'd0);
    checkOutput("mrBusy", 32'(busy), 32'd0);
    checkOutput("mrReady", 32'(bus.job_ready), 32'd1);
    checkOutput("mrJobsDone", 32'(jobsDone), 32'd0);
    checkOutput("mrPix", 32'(bus.pix_base_addr), 32'd0);
    expQ.delete();
    expDone = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    riseBase = riseCount;
    waitCycles(10);
    checkOutput("mrNoRestart", 32'(riseCount - riseBase), 32'd0);
    checkOutput("mrIdle", 32'(busy), 32'd0);

    checkOutput("noStrayPulses", 32'(strayCount), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
